da_shift_acc: RTL and testbench

- Bit-plane shift-accumulator for the DA multiplier datapath; sits directly downstream of the pairwise adder-tree stages.
- The final tree stage delivers one unsigned partial sum per coefficient bit plane, LSB plane first.
- This block weights each plane by 2^k and accumulates BITS planes into one word.
- With SIGNED=1, the MSB plane is subtracted (two's-complement weight).
- The completed result is offered on a valid/ready output register.

---
 rtl/da_pkg.sv | 11 +
 rtl/da_shift_acc.sv | 133 +++++++++++++
 tb/tb_da_shift_acc.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/da_pkg.sv
// Shared types and helpers for the DA multiplier datapath stages.
package da_pkg;

   typedef enum logic [1:0] {IDLE, ACC, HOLD} da_acc_state_t;

   // Output width of a bit-plane accumulator: one sign bit above the unsigned maximum.
   function automatic int da_out_width(input int psize, input int bits);
      return psize + bits + 1;
   endfunction

endpackage

// File: rtl/da_shift_acc.sv
// Bit-plane shift-accumulator: weights each incoming plane partial sum by 2^k and
// accumulates BITS planes (MSB plane subtracted when SIGNED=1) into one result word.
module da_shift_acc
   import da_pkg::*;
#(
   parameter int PSIZE  = 9,
   parameter int BITS   = 8,
   parameter int SIGNED = 1,
   localparam int OSIZE = da_out_width(PSIZE, BITS)
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [PSIZE-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OSIZE-1:0] out_data,
   output logic             sync_err
);

   localparam int CW = $clog2(BITS);
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   da_acc_state_t            state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic signed [OSIZE-1:0]  acc_q, acc_d;
   logic signed [OSIZE-1:0]  out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic                     sync_err_q, sync_err_d;

   logic                     accept;
   logic signed [OSIZE-1:0]  ext_data;
   logic signed [OSIZE-1:0]  term;
   logic signed [OSIZE-1:0]  acc_sum;

   assign in_ready = (state_q == HOLD) ? out_ready : 1'b1;
   assign accept   = in_valid && in_ready;

   // Plane term and add/sub; the MSB plane carries negative weight in signed mode.
   always_comb begin
      ext_data = signed'({{(OSIZE - PSIZE){1'b0}}, in_data});
      term     = ext_data <<< cnt_q;
      if ((cnt_q == LAST) && (SIGNED != 0)) begin
         acc_sum = acc_q - term;
      end else begin
         acc_sum = acc_q + term;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      sync_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_sof) begin
                  acc_d   = ext_data;
                  cnt_d   = CW'(1);
                  state_d = ACC;
               end else begin
                  sync_err_d = 1'b1;
               end
            end
         end
         ACC: begin
            if (accept) begin
               if (in_sof) begin
                  sync_err_d = 1'b1;
                  acc_d      = ext_data;
                  cnt_d      = CW'(1);
               end else if (cnt_q == LAST) begin
                  out_data_d  = acc_sum;
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  cnt_d       = '0;
                  state_d     = HOLD;
               end else begin
                  acc_d = acc_sum;
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         HOLD: begin
            // A frame cannot complete on the release edge, so valid always drops here.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
               if (in_valid) begin
                  if (in_sof) begin
                     acc_d   = ext_data;
                     cnt_d   = CW'(1);
                     state_d = ACC;
                  end else begin
                     sync_err_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_da_shift_acc.sv
// Bench for da_shift_acc: signed and unsigned instances share stimulus; a scoreboard
// queue holds expected results checked at each output handshake.
module tb_da_shift_acc;
   import da_pkg::*;

   localparam int PW = 9;
   localparam int BW = 4;
   localparam int OW = da_out_width(PW, BW);

   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic [PW-1:0] in_data = '0;
   logic          out_ready = 1'b1;
   logic          in_ready_s, in_ready_u;
   logic          out_valid_s, out_valid_u;
   logic [OW-1:0] out_data_s, out_data_u;
   logic          sync_err_s, sync_err_u;

   da_shift_acc #(.PSIZE(PW), .BITS(BW), .SIGNED(1)) dut_s (
      .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_data(out_data_s), .sync_err(sync_err_s)
   );

   da_shift_acc #(.PSIZE(PW), .BITS(BW), .SIGNED(0)) dut_u (
      .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
      .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid_u),
      .out_ready(out_ready), .out_data(out_data_u), .sync_err(sync_err_u)
   );

   always #5 clock = ~clock;

   typedef struct {
      int es;
      int eu;
      int cyc;
   } exp_t;

   typedef struct {
      logic [PW-1:0] d0, d1, d2, d3;
      int            es;
      int            eu;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   serr_s = 0;
   int   serr_u = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output monitor: latency on the rising edge of valid, value at handshake.
   initial begin
      logic pv;
      exp_t e;
      pv = 1'b0;
      forever begin
         @(negedge clock);
         if (sync_err_s) serr_s++;
         if (sync_err_u) serr_u++;
         if (rst_n) begin
            if (out_valid_s && !pv && sb.size() > 0) chk("latency", cyc, sb[0].cyc);
            if (out_valid_s && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("data_signed", int'($signed(out_data_s)), e.es);
                  chk("data_unsigned", int'(out_data_u), e.eu);
                  chk("valid_unsigned", int'(out_valid_u), 1);
               end
            end
         end
         pv = out_valid_s;
      end
   end

   task automatic send_beat(input logic [PW-1:0] d, input logic sof,
                            input bit last, input int es, input int eu);
      bit got;
      got = 1'b0;
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = d;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (in_ready_s) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("in_ready_timeout", 0, 1);
      end else if (last) begin
         sb.push_back('{es: es, eu: eu, cyc: cyc + 1});
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input vec_t v);
      send_beat(v.d0, 1'b1, 1'b0, 0, 0);
      send_beat(v.d1, 1'b0, 1'b0, 0, 0);
      send_beat(v.d2, 1'b0, 1'b0, 0, 0);
      send_beat(v.d3, 1'b0, 1'b1, v.es, v.eu);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      sb.delete();
      @(posedge clock);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      vec_t vecs[6];
      vec_t v;
      int   c0, s0;

      vecs[0] = '{d0: 9'd1,   d1: 9'd2,   d2: 9'd3,   d3: 9'd4,   es: -15,   eu: 49};
      vecs[1] = '{d0: 9'd511, d1: 9'd511, d2: 9'd511, d3: 9'd511, es: -511,  eu: 7665};
      vecs[2] = '{d0: 9'd0,   d1: 9'd0,   d2: 9'd0,   d3: 9'd0,   es: 0,     eu: 0};
      vecs[3] = '{d0: 9'd0,   d1: 9'd0,   d2: 9'd0,   d3: 9'd511, es: -4088, eu: 4088};
      vecs[4] = '{d0: 9'd511, d1: 9'd0,   d2: 9'd0,   d3: 9'd0,   es: 511,   eu: 511};
      vecs[5] = '{d0: 9'd3,   d1: 9'd7,   d2: 9'd0,   d3: 9'd2,   es: 1,     eu: 33};

      repeat (3) @(posedge clock);
      #1;
      rst_n = 1'b1;
      @(negedge clock);
      chk("reset_out_valid", int'(out_valid_s), 0);
      chk("reset_out_data", int'(out_data_s), 0);
      chk("reset_sync_err", int'(sync_err_s), 0);
      chk("reset_in_ready", int'(in_ready_s), 1);
      @(posedge clock);
      #1;

      // Back-to-back frames: no bubbles allowed with out_ready high.
      c0 = cyc;
      for (int i = 0; i < 6; i++) send_frame(vecs[i]);
      chk("throughput_cycles", cyc - c0, 6 * BW);
      idle_cycles(3);

      // Backpressure: result held while the next sof beat waits.
      send_frame(vecs[0]);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sof    = 1'b1;
      in_data   = 9'd5;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("bp_out_valid", int'(out_valid_s), 1);
         chk("bp_out_data", int'($signed(out_data_s)), -15);
         chk("bp_in_ready", int'(in_ready_s), 0);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      send_beat(9'd5, 1'b1, 1'b0, 0, 0);
      send_beat(9'd6, 1'b0, 1'b0, 0, 0);
      send_beat(9'd7, 1'b0, 1'b0, 0, 0);
      send_beat(9'd8, 1'b0, 1'b1, -19, 109);
      idle_cycles(3);

      // Non-sof beat in IDLE.
      s0 = serr_s;
      send_beat(9'd3, 1'b0, 1'b0, 0, 0);
      idle_cycles(3);
      chk("idle_sync_err_s", serr_s - s0, 1);
      chk("idle_sync_err_u", serr_u - s0, 1);

      // sof arriving as plane 2 restarts the frame.
      s0 = serr_s;
      send_beat(9'd9, 1'b1, 1'b0, 0, 0);
      send_beat(9'd9, 1'b0, 1'b0, 0, 0);
      send_beat(9'd1, 1'b1, 1'b0, 0, 0);
      send_beat(9'd1, 1'b0, 1'b0, 0, 0);
      send_beat(9'd1, 1'b0, 1'b0, 0, 0);
      send_beat(9'd1, 1'b0, 1'b1, -1, 15);
      idle_cycles(3);
      chk("restart_sync_err", serr_s - s0, 1);

      // Reset after plane 2: the frame must be gone, so a stray beat is a violation.
      send_beat(9'd100, 1'b1, 1'b0, 0, 0);
      send_beat(9'd100, 1'b0, 1'b0, 0, 0);
      send_beat(9'd100, 1'b0, 1'b0, 0, 0);
      pulse_reset();
      @(negedge clock);
      chk("midframe_rst_valid", int'(out_valid_s), 0);
      chk("midframe_rst_data", int'(out_data_s), 0);
      @(posedge clock);
      #1;
      s0 = serr_s;
      send_beat(9'd7, 1'b0, 1'b0, 0, 0);
      idle_cycles(3);
      chk("post_rst_stray_beat", serr_s - s0, 1);
      v = '{d0: 9'd1, d1: 9'd1, d2: 9'd1, d3: 9'd1, es: -1, eu: 15};
      send_frame(v);
      idle_cycles(3);

      // Reset during HOLD drops the pending result.
      send_frame(vecs[1]);
      out_ready = 1'b0;
      @(negedge clock);
      chk("hold_valid_before_rst", int'(out_valid_s), 1);
      @(posedge clock);
      #1;
      pulse_reset();
      @(negedge clock);
      chk("hold_rst_valid", int'(out_valid_s), 0);
      chk("hold_rst_data", int'(out_data_s), 0);
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      idle_cycles(3);
      send_frame(vecs[5]);

      for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clock);
      idle_cycles(2);
      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
